// File: rtl/tdm_mux_param_if.sv
// Bus bundle for the parametrised TDM multiplexer: lane inputs and control in, serialised stream out.
interface tdm_mux_param_if #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned DWELL_W  = 4
);
    logic                      en;
    logic [CHANNELS-1:0]       ch_mask;
    logic [DWELL_W-1:0]        dwell;
    logic [CHANNELS*WIDTH-1:0] in_bus;
    logic [WIDTH-1:0]          out;
    logic [SEL_W-1:0]          sel;
    logic                      out_valid;
    logic                      frame_start;

    modport master (
        output en, ch_mask, dwell, in_bus,
        input  out, sel, out_valid, frame_start
    );

    modport slave (
        input  en, ch_mask, dwell, in_bus,
        output out, sel, out_valid, frame_start
    );
endinterface

// File: rtl/tdm_mux_param.sv
// Parametrised TDM multiplexer: rotates over enabled lanes with a programmable slot dwell,
// emitting a registered lane value, its index, a valid flag and a frame-start strobe.
module tdm_mux_param #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned DWELL_W  = 4
) (
    input  logic           clk,
    input  logic           rst,
    tdm_mux_param_if.slave bus
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               valid_q, valid_d;
    logic               fs_q, fs_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic               go;
    logic [SEL_W-1:0]   first_sel;
    logic [SEL_W-1:0]   next_sel;

    // Index of the lowest set mask bit (0 when the mask is empty).
    function automatic logic [SEL_W-1:0] lowest_set(input logic [CHANNELS-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (m[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

    // Next set mask bit strictly above cur, wrapping to the lowest set bit.
    function automatic logic [SEL_W-1:0] next_set(input logic [CHANNELS-1:0] m,
                                                   input logic [SEL_W-1:0]    cur);
        logic [SEL_W-1:0] r;
        logic             found;
        r     = lowest_set(m);
        found = 1'b0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (!found && m[i] && (i > int'(cur))) begin
                r     = SEL_W'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Extract lane s from the packed input bus.
    function automatic logic [WIDTH-1:0] lane(input logic [CHANNELS*WIDTH-1:0] b,
                                              input logic [SEL_W-1:0]          s);
        int unsigned base;
        base = 32'(s) * WIDTH;
        return b[base +: WIDTH];
    endfunction

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            cnt_q   <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            fs_q    <= fs_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
        end
    end

    // Next-state logic: start/stop, slot counting, end-of-slot or aborted-slot rotation.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        fs_d      = 1'b0;
        cnt_d     = cnt_q;
        dwell_d   = dwell_q;
        go        = bus.en && (bus.ch_mask != '0);
        first_sel = lowest_set(bus.ch_mask);
        next_sel  = next_set(bus.ch_mask, sel_q);

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (go) begin
                    state_d = RUN;
                    sel_d   = first_sel;
                    out_d   = lane(bus.in_bus, first_sel);
                    valid_d = 1'b1;
                    fs_d    = 1'b1;
                    cnt_d   = '0;
                    dwell_d = bus.dwell;
                end
            end
            RUN: begin
                if (!go) begin
                    // Stopping wins over any slot boundary on the same edge.
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else if ((cnt_q == dwell_q) || !bus.ch_mask[sel_q]) begin
                    // Slot end, or the current lane was masked off mid-slot.
                    sel_d   = next_sel;
                    out_d   = lane(bus.in_bus, next_sel);
                    fs_d    = (next_sel == first_sel);
                    cnt_d   = '0;
                    dwell_d = bus.dwell;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                    out_d = lane(bus.in_bus, sel_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out         = out_q;
    assign bus.sel         = sel_q;
    assign bus.out_valid   = valid_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_tdm_mux_param.sv
// Testbench for tdm_mux_param: directed scenarios followed by randomised traffic,
// all checked against a slot-list reference model.
module tb_tdm_mux_param;

    localparam int unsigned WIDTH    = 2;
    localparam int unsigned CHANNELS = 4;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned DWELL_W  = 4;

    logic clk = 1'b0;
    logic rst;

    tdm_mux_param_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

    tdm_mux_param #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: running flag, current lane, cycles left in slot.
    bit               m_run;
    int               m_sel;
    int               m_left;
    logic [WIDTH-1:0] m_out;
    bit               m_valid;
    bit               m_fs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_run = 0; m_sel = 0; m_left = 0; m_out = '0; m_valid = 0; m_fs = 0;
    endtask

    // One rising edge of the model, evaluated from the inputs present at that edge.
    task automatic model_edge();
        int en_list[$];
        int nxt;
        bit found;
        for (int i = 0; i < int'(CHANNELS); i++)
            if (bus.ch_mask[i]) en_list.push_back(i);
        if (!bus.en || en_list.size() == 0) begin
            m_run = 0; m_valid = 0; m_fs = 0;
            return;
        end
        if (!m_run || m_left == 0 || !bus.ch_mask[m_sel]) begin
            nxt   = en_list[0];
            found = 0;
            if (m_run)
                foreach (en_list[k])
                    if (!found && en_list[k] > m_sel) begin nxt = en_list[k]; found = 1; end
            m_fs   = (nxt == en_list[0]);
            m_sel  = nxt;
            m_left = int'(bus.dwell);
            m_run  = 1;
        end else begin
            m_left--;
            m_fs = 0;
        end
        m_valid = 1;
        m_out   = bus.in_bus[m_sel*WIDTH +: WIDTH];
    endtask

    // Advance one clock, update the model and compare all outputs.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".out"},   32'(bus.out),         32'(m_out));
        chk({tag, ".sel"},   32'(bus.sel),         32'(m_sel));
        chk({tag, ".valid"}, 32'(bus.out_valid),   32'(m_valid));
        chk({tag, ".fs"},    32'(bus.frame_start), 32'(m_fs));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, ".out0"},   32'(bus.out),         32'd0);
        chk({tag, ".sel0"},   32'(bus.sel),         32'd0);
        chk({tag, ".valid0"}, 32'(bus.out_valid),   32'd0);
        chk({tag, ".fs0"},    32'(bus.frame_start), 32'd0);
    endtask

    initial begin
        rst         = 1'b0;
        bus.en      = 1'b0;
        bus.ch_mask = '0;
        bus.dwell   = '0;
        bus.in_bus  = 8'hE4;   // lanes 0,1,2,3 carry values 0,1,2,3
        model_reset();
        #12;
        check_cleared("reset");
        rst = 1'b1;

        // 1: full mask, dwell 0 -> 0,1,2,3 repeating
        bus.en = 1'b1; bus.ch_mask = 4'b1111; bus.dwell = '0;
        for (int i = 0; i < 8; i++) begin
            tick("t1");
            chk("t1.seq", 32'(bus.out), 32'(i % 4));
            chk("t1.fs_seq", 32'(bus.frame_start), 32'(i % 4 == 0));
        end

        // 2: dwell 2 -> each value held three cycles
        bus.en = 1'b0; tick("t2.stop");
        bus.en = 1'b1; bus.dwell = 4'd2;
        for (int i = 0; i < 13; i++) begin
            tick("t2");
            chk("t2.seq", 32'(bus.out), 32'((i / 3) % 4));
            chk("t2.fs_seq", 32'(bus.frame_start), 32'(i % 12 == 0));
        end

        // 3: sparse mask 1010, then empty mask
        bus.en = 1'b0; tick("t3.stop");
        bus.en = 1'b1; bus.ch_mask = 4'b1010; bus.dwell = '0;
        for (int i = 0; i < 4; i++) begin
            tick("t3");
            chk("t3.sel_seq", 32'(bus.sel), (i % 2 == 0) ? 32'd1 : 32'd3);
        end
        bus.ch_mask = 4'b0000;
        tick("t3.empty");
        chk("t3.valid_off", 32'(bus.out_valid), 32'd0);
        chk("t3.out_hold", 32'(bus.out), 32'd3);

        // 4: clear the current lane's mask bit mid-slot
        bus.en = 1'b0; tick("t4.stop");
        bus.en = 1'b1; bus.ch_mask = 4'b1111; bus.dwell = 4'd3;
        for (int i = 0; i < 10; i++) tick("t4.run");
        chk("t4.sel2", 32'(bus.sel), 32'd2);
        bus.ch_mask = 4'b1011;
        tick("t4.abort");
        chk("t4.sel3", 32'(bus.sel), 32'd3);
        for (int i = 0; i < 3; i++) begin
            tick("t4.full");
            chk("t4.hold3", 32'(bus.sel), 32'd3);
        end
        tick("t4.wrap");
        chk("t4.wrap0", 32'(bus.sel), 32'd0);

        // 5: asynchronous reset mid-slot
        bus.ch_mask = 4'b1111; bus.dwell = 4'd1;
        for (int i = 0; i < 3; i++) tick("t5.run");
        #3 rst = 1'b0;
        model_reset();
        #1 check_cleared("t5.rst");
        #2 rst = 1'b1;
        tick("t5.restart");
        chk("t5.sel0", 32'(bus.sel), 32'd0);
        chk("t5.fs1", 32'(bus.frame_start), 32'd1);

        // 6: en drops on the last cycle of the sel=1 slot
        for (int i = 0; i < 3; i++) tick("t6.run");
        bus.en = 1'b0;
        tick("t6.stop");
        chk("t6.sel_hold", 32'(bus.sel), 32'd1);
        chk("t6.valid_off", 32'(bus.out_valid), 32'd0);
        bus.en = 1'b1;
        tick("t6.restart");
        chk("t6.sel0", 32'(bus.sel), 32'd0);
        chk("t6.fs1", 32'(bus.frame_start), 32'd1);

        // Randomised traffic: live lane data, mask/dwell/en changes, occasional reset
        for (int c = 0; c < 400; c++) begin
            bus.in_bus = 8'($urandom);
            if ($urandom_range(0, 7) == 0) bus.ch_mask = 4'($urandom);
            if ($urandom_range(0, 5) == 0) bus.dwell = 4'($urandom_range(0, 3));
            bus.en = ($urandom_range(0, 11) != 0);
            if ($urandom_range(0, 63) == 0) begin
                #2 rst = 1'b0;
                model_reset();
                #1 check_cleared("rnd.rst");
                #2 rst = 1'b1;
            end
            tick("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
